// File: rtl/vxe_biu_rwarb.sv
// Round-robin arbiter that merges the BIU write and read paths onto one
// single-ported target access port, with ack timeout and one-cycle accept pulses.
module vxe_biu_rwarb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   biu_waddr,
  input  logic                    biu_wenable,
  input  logic [DATA_WIDTH-1:0]   biu_wdata,
  input  logic [DATA_WIDTH/8-1:0] biu_wben,
  output logic                    biu_waccept,
  output logic                    biu_werror,
  input  logic [ADDR_WIDTH-1:0]   biu_raddr,
  input  logic                    biu_renable,
  output logic [DATA_WIDTH-1:0]   biu_rdata,
  output logic                    biu_raccept,
  output logic                    biu_rerror,
  output logic                    tgt_req,
  output logic                    tgt_wr,
  output logic [ADDR_WIDTH-1:0]   tgt_addr,
  output logic [DATA_WIDTH-1:0]   tgt_wdata,
  output logic [DATA_WIDTH/8-1:0] tgt_ben,
  input  logic                    tgt_ack,
  input  logic [DATA_WIDTH-1:0]   tgt_rdata,
  input  logic                    tgt_err
);

  localparam int BEN_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    last_wr_q;
  logic                    tgt_req_q;
  logic                    tgt_wr_q;
  logic [ADDR_WIDTH-1:0]   tgt_addr_q;
  logic [DATA_WIDTH-1:0]   tgt_wdata_q;
  logic [BEN_W-1:0]        tgt_ben_q;
  logic                    waccept_q;
  logic                    werror_q;
  logic                    raccept_q;
  logic                    rerror_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    grant_wr_d;

  // On a conflict the path not served last wins; last_wr_q=0 favours the write.
  always_comb begin
    grant_wr_d = biu_wenable && (!biu_renable || !last_wr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_wr_q   <= 1'b0;
      tgt_req_q   <= 1'b0;
      tgt_wr_q    <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      tgt_ben_q   <= '0;
      waccept_q   <= 1'b0;
      werror_q    <= 1'b0;
      raccept_q   <= 1'b0;
      rerror_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (biu_wenable || biu_renable) begin
            tgt_req_q  <= 1'b1;
            tgt_wr_q   <= grant_wr_d;
            tgt_addr_q <= grant_wr_d ? biu_waddr : biu_raddr;
            if (grant_wr_d) begin
              tgt_wdata_q <= biu_wdata;
              tgt_ben_q   <= biu_wben;
            end else begin
              tgt_ben_q   <= '1;
            end
            cnt_q     <= '0;
            last_wr_q <= grant_wr_d;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          // An ack arriving in the timeout cycle still completes normally.
          if (tgt_ack) begin
            tgt_req_q <= 1'b0;
            waccept_q <= tgt_wr_q;
            raccept_q <= !tgt_wr_q;
            werror_q  <= tgt_wr_q && tgt_err;
            rerror_q  <= !tgt_wr_q && tgt_err;
            if (!tgt_wr_q) rdata_q <= tgt_rdata;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            tgt_req_q <= 1'b0;
            waccept_q <= tgt_wr_q;
            raccept_q <= !tgt_wr_q;
            werror_q  <= tgt_wr_q;
            rerror_q  <= !tgt_wr_q;
            if (!tgt_wr_q) rdata_q <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          waccept_q <= 1'b0;
          raccept_q <= 1'b0;
          werror_q  <= 1'b0;
          rerror_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tgt_req     = tgt_req_q;
  assign tgt_wr      = tgt_wr_q;
  assign tgt_addr    = tgt_addr_q;
  assign tgt_wdata   = tgt_wdata_q;
  assign tgt_ben     = tgt_ben_q;
  assign biu_waccept = waccept_q;
  assign biu_werror  = werror_q;
  assign biu_raccept = raccept_q;
  assign biu_rerror  = rerror_q;
  assign biu_rdata   = rdata_q;

endmodule

// File: doc/vxe_biu_rwarb.md
# vxe_biu_rwarb

Arbiter and sequencer that sits behind the AXI4 slave BIU. It merges the BIU's independent write path and read path onto one single-ported register/target access port. It grants one access at a time with round-robin fairness, waits for the target's acknowledge, and returns a one-cycle accept pulse to the served path. If the target does not acknowledge within a bounded number of cycles, the access is completed with an error.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of BIU and target port
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- TIMEOUT, 16, maximum cycles in ACCESS waiting for tgt_ack; must be ≥ 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- biu_waddr  in  ADDR_WIDTH  write address, stable while biu_wenable
- biu_wenable  in  1  write request pending
- biu_wdata  in  DATA_WIDTH  write data
- biu_wben  in  DATA_WIDTH/8  write byte enables
- biu_waccept  out  1  one-cycle pulse: write completed
- biu_werror  out  1  write error, qualified by biu_waccept
- biu_raddr  in  ADDR_WIDTH  read address, stable while biu_renable
- biu_renable  in  1  read request pending
- biu_rdata  out  DATA_WIDTH  read data, qualified by biu_raccept
- biu_raccept  out  1  one-cycle pulse: read completed
- biu_rerror  out  1  read error, qualified by biu_raccept
- tgt_req  out  1  target access strobe
- tgt_wr  out  1  1 = write, 0 = read
- tgt_addr  out  ADDR_WIDTH  target address
- tgt_wdata  out  DATA_WIDTH  target write data
- tgt_ben  out  DATA_WIDTH/8  target byte enables (all ones for reads)
- tgt_ack  in  1  target completion, may be combinational from tgt_req
- tgt_rdata  in  DATA_WIDTH  read data, valid with tgt_ack
- tgt_err  in  1  target error, valid with tgt_ack

## Operation
FSM states:
- IDLE
  - No request pending: stay in IDLE.
  - Exactly one of biu_wenable / biu_renable high: grant that path.
  - Both high: grant the path not served last. last_wr flag resets to 0, so the write wins the first conflict.
  - On grant: register tgt_wr/addr/wdata/ben from the granted path, set tgt_req, clear the timeout counter, update last_wr, go to ACCESS.
- ACCESS
  - tgt_req held high, all tgt_* outputs stable.
  - tgt_ack=1: capture tgt_rdata (reads only) and tgt_err into result registers, drop tgt_req, go to DONE.
  - Else, if counter == TIMEOUT-1: abort. Drop tgt_req, error=1, rdata=0, go to DONE.
  - Else increment the counter (width clog2(TIMEOUT), saturating, no wrap).
  - tgt_ack in the same cycle as the timeout condition: the ack wins.
- DONE
  - Assert the accept of the granted path for exactly one cycle, with its error (and biu_rdata for reads) valid.
  - The other path's accept/error stay 0.
  - Go to IDLE.

Boundary conditions:
- The BIU deasserts enable on the cycle after accept, so the served path is seen low in the following IDLE. There is no double service.
- An enable deasserting mid-access is a protocol violation. The access still completes and accept still pulses.
- tgt_ack outside ACCESS is ignored.
- rst in any state: immediate return to IDLE. Any in-flight access is dropped with no accept. last_wr is cleared.

## Timing
- Reset values:
  - tgt_req, tgt_wr, biu_waccept, biu_raccept, biu_werror, biu_rerror = 0.
  - tgt_addr, tgt_wdata, biu_rdata = 0; tgt_ben = 0.
  - State = IDLE, counter = 0, last_wr = 0.
- All outputs are registered. No combinational path from any input to any output.
- Latency: enable seen in IDLE at cycle T → tgt_req high T+1 → ack at T+1+k (k ≥ 0) → accept at T+2+k → IDLE at T+3+k.
- Minimum access-to-access spacing is 3 cycles.
- Timeout case: tgt_req is high for exactly TIMEOUT cycles; accept follows one cycle after tgt_req drops.
- biu_rdata holds its last value until the next read completes.

## Test plan
- Reset, then single write (addr 0x10, data 0xA5A5A5A5, ben 0xF), tgt_ack on the first ACCESS cycle → tgt_req high 1 cycle with those values; biu_waccept=1 exactly 2 cycles after the enable was seen, biu_werror=0.
- Single read (addr 0x20), tgt_ack after 3 wait cycles with rdata 0xDEADBEEF → biu_raccept pulse with biu_rdata=0xDEADBEEF, biu_rerror=0, tgt_ben=0xF, tgt_wr=0.
- Both enables high continuously for 4 transactions → grant order W, R, W, R; each accept is 1 cycle wide; never both accepts high together.
- Read, tgt_ack never asserted, TIMEOUT=16 → tgt_req high exactly 16 cycles; biu_raccept with biu_rerror=1, biu_rdata=0. Repeat with ack on cycle 16 → ack wins, rerror = tgt_err.
- Write with tgt_ack=1 and tgt_err=1 → biu_werror=1 on the accept cycle. tgt_ack pulsed while in IDLE → no accept.
- rst asserted during ACCESS → next cycle tgt_req=0, no accept pulse, all outputs at reset values; a read pending after reset is served first only if no write is pending.
